// File: rtl/stoplight_pkg.sv
// Shared types and helpers for the stoplight lamp monitor.
//   phase_t      : decoded lamp pattern (four legal phases plus BAD)
//   mon_state_t  : monitor tracking state
//   successor()  : legal next phase in the NSG->NSY->EWG->EWY->NSG ring
//   DEF_*_CYC    : default dwell lengths in clk cycles
package stoplight_pkg;

  typedef enum logic [2:0] {
    NSG = 3'd0,
    NSY = 3'd1,
    EWG = 3'd2,
    EWY = 3'd3,
    BAD = 3'd4
  } phase_t;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  localparam int DEF_NSG_CYC = 11;
  localparam int DEF_NSY_CYC = 4;
  localparam int DEF_EWG_CYC = 7;
  localparam int DEF_EWY_CYC = 4;
  localparam int DEF_DW      = 5;

  function automatic phase_t successor(input phase_t p);
    case (p)
      NSG:     return NSY;
      NSY:     return EWG;
      EWG:     return EWY;
      EWY:     return NSG;
      default: return BAD;
    endcase
  endfunction

endpackage

// File: rtl/stoplight_decode.sv
// Combinational lamp-pattern decoder.
// Ports:
//   ns_red_i/ns_yellow_i/ns_green_i : north-south lamps
//   ew_red_i/ew_yellow_i/ew_green_i : east-west lamps
//   phase_o                         : decoded phase, BAD for any illegal pattern
module stoplight_decode
  import stoplight_pkg::*;
(
  input  logic   ns_red_i,
  input  logic   ns_yellow_i,
  input  logic   ns_green_i,
  input  logic   ew_red_i,
  input  logic   ew_yellow_i,
  input  logic   ew_green_i,
  output phase_t phase_o
);

  // Exactly one lamp lit on a side.
  logic ns_r_only, ns_y_only, ns_g_only;
  logic ew_r_only, ew_y_only, ew_g_only;

  assign ns_r_only = ns_red_i    & ~ns_yellow_i & ~ns_green_i;
  assign ns_y_only = ns_yellow_i & ~ns_red_i    & ~ns_green_i;
  assign ns_g_only = ns_green_i  & ~ns_red_i    & ~ns_yellow_i;
  assign ew_r_only = ew_red_i    & ~ew_yellow_i & ~ew_green_i;
  assign ew_y_only = ew_yellow_i & ~ew_red_i    & ~ew_green_i;
  assign ew_g_only = ew_green_i  & ~ew_red_i    & ~ew_yellow_i;

  always_comb begin
    phase_o = BAD;
    if (ns_g_only && ew_r_only)      phase_o = NSG;
    else if (ns_y_only && ew_r_only) phase_o = NSY;
    else if (ns_r_only && ew_g_only) phase_o = EWG;
    else if (ns_r_only && ew_y_only) phase_o = EWY;
  end

endmodule

// File: rtl/stoplight_monitor.sv
// Passive checker on the intersection controller's six lamp outputs.
// Tracks the phase ring and (optionally) per-phase dwell, flags errors.
// Optional feature macro: STOPLIGHT_MON_TIMING_EN builds the dwell counter
// and timing checks; without it timing_err is tied low.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   northsouth_*/eastwest_* : lamp inputs (sampled every rising edge)
//   clear_err         : clears err_sticky (a same-cycle pulse takes priority)
//   phase             : last legal phase seen (0=NSG 1=NSY 2=EWG 3=EWY)
//   locked            : monitor is tracking the sequence
//   conflict_err/seq_err/timing_err : one-cycle error pulses
//   err_sticky        : OR of all pulses since reset/clear
//   cycles_done       : count of clean EWY->NSG transitions, wraps
module stoplight_monitor
  import stoplight_pkg::*;
#(
  parameter int NSG_CYC = DEF_NSG_CYC,
  parameter int NSY_CYC = DEF_NSY_CYC,
  parameter int EWG_CYC = DEF_EWG_CYC,
  parameter int EWY_CYC = DEF_EWY_CYC,
  parameter int DW      = DEF_DW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       northsouth_red,
  input  logic       northsouth_yellow,
  input  logic       northsouth_green,
  input  logic       eastwest_red,
  input  logic       eastwest_yellow,
  input  logic       eastwest_green,
  input  logic       clear_err,
  output logic [1:0] phase,
  output logic       locked,
  output logic       conflict_err,
  output logic       seq_err,
  output logic       timing_err,
  output logic       err_sticky,
  output logic [7:0] cycles_done
);

  // Dwell must be able to exceed every expected value before saturating.
  if ((NSG_CYC >= 2**DW - 1) || (NSY_CYC >= 2**DW - 1) ||
      (EWG_CYC >= 2**DW - 1) || (EWY_CYC >= 2**DW - 1)) begin : g_param_err
    $error("stoplight_monitor: dwell constants must be below 2**DW-1");
  end

  phase_t dec_phase;

  stoplight_decode u_decode (
    .ns_red_i    (northsouth_red),
    .ns_yellow_i (northsouth_yellow),
    .ns_green_i  (northsouth_green),
    .ew_red_i    (eastwest_red),
    .ew_yellow_i (eastwest_yellow),
    .ew_green_i  (eastwest_green),
    .phase_o     (dec_phase)
  );

  mon_state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       prev_valid_q, prev_valid_d;  // phase_q holds a usable SYNC reference
  logic       conflict_q, conflict_d;
  logic       seq_q, seq_d;
  logic       timing_d;
  logic       sticky_q, sticky_d;
  logic [7:0] cycles_q, cycles_d;
  phase_t     cur_phase;

  assign cur_phase = phase_t'({1'b0, phase_q});

`ifdef STOPLIGHT_MON_TIMING_EN
  logic [DW-1:0] dwell_q, dwell_d;
  logic          timing_q;

  function automatic logic [DW-1:0] exp_cyc(input phase_t p);
    case (p)
      NSG:     return DW'(NSG_CYC);
      NSY:     return DW'(NSY_CYC);
      EWG:     return DW'(EWG_CYC);
      EWY:     return DW'(EWY_CYC);
      default: return '0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    prev_valid_d = prev_valid_q;
    conflict_d   = 1'b0;
    seq_d        = 1'b0;
    timing_d     = 1'b0;
    cycles_d     = cycles_q;
`ifdef STOPLIGHT_MON_TIMING_EN
    dwell_d      = dwell_q;
`endif

    if (dec_phase == BAD) begin
      conflict_d   = 1'b1;
      prev_valid_d = 1'b0;
      state_d      = SYNC;
    end else if (state_q == SYNC) begin
      // The first phase after sync loss is mid-dwell, so only a change locks.
      if (prev_valid_q && (dec_phase != cur_phase)) begin
        state_d = TRACK;
`ifdef STOPLIGHT_MON_TIMING_EN
        dwell_d = DW'(1);
`endif
      end
      phase_d      = dec_phase[1:0];
      prev_valid_d = 1'b1;
    end else if (dec_phase == cur_phase) begin
`ifdef STOPLIGHT_MON_TIMING_EN
      // Overstay fires once, on the sample after dwell reaches the target.
      timing_d = (dwell_q == exp_cyc(cur_phase));
      if (dwell_q != '1) dwell_d = dwell_q + DW'(1);
`endif
    end else begin
      seq_d = (dec_phase != successor(cur_phase));
`ifdef STOPLIGHT_MON_TIMING_EN
      // dwell above target means the overstay was already reported.
      timing_d = (dwell_q < exp_cyc(cur_phase));
      dwell_d  = DW'(1);
`endif
      if ((cur_phase == EWY) && (dec_phase == NSG) && !seq_d && !timing_d)
        cycles_d = cycles_q + 8'd1;
      phase_d = dec_phase[1:0];
    end

    if (conflict_d || seq_d || timing_d) sticky_d = 1'b1;
    else if (clear_err)                  sticky_d = 1'b0;
    else                                 sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      phase_q      <= 2'd0;
      prev_valid_q <= 1'b0;
      conflict_q   <= 1'b0;
      seq_q        <= 1'b0;
      sticky_q     <= 1'b0;
      cycles_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_valid_q <= prev_valid_d;
      conflict_q   <= conflict_d;
      seq_q        <= seq_d;
      sticky_q     <= sticky_d;
      cycles_q     <= cycles_d;
    end
  end

`ifdef STOPLIGHT_MON_TIMING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q  <= '0;
      timing_q <= 1'b0;
    end else begin
      dwell_q  <= dwell_d;
      timing_q <= timing_d;
    end
  end
  assign timing_err = timing_q;
`else
  assign timing_err = 1'b0;
`endif

  assign phase        = phase_q;
  assign locked       = (state_q == TRACK);
  assign conflict_err = conflict_q;
  assign seq_err      = seq_q;
  assign err_sticky   = sticky_q;
  assign cycles_done  = cycles_q;

endmodule

// File: doc/stoplight_monitor.md
Name: stoplight_monitor

Overview:
- Passive checker on the six stoplight lamp outputs of the intersection controller, i.e. the consuming end of the lamp interface.
- Decodes the lamp pattern into a phase and tracks the required phase sequence and the dwell time of each phase.
- Raises one-cycle error pulses plus a sticky error flag, and counts completed light cycles.
- Sits beside the controller in the top level and in benches; it never drives the lamps.

Parameters:
- NSG_CYC, 11, required NS green dwell in clk cycles
- NSY_CYC, 4, required NS yellow dwell
- EWG_CYC, 7, required EW green dwell
- EWY_CYC, 4, required EW yellow dwell
- DW, 5, dwell counter width; every *_CYC must be < 2**DW - 1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- northsouth_red  in  1  lamp
- northsouth_yellow  in  1  lamp
- northsouth_green  in  1  lamp
- eastwest_red  in  1  lamp
- eastwest_yellow  in  1  lamp
- eastwest_green  in  1  lamp
- clear_err  in  1  clears err_sticky
- phase  out  2  last legal phase: 0=NSG, 1=NSY, 2=EWG, 3=EWY
- locked  out  1  monitor is in TRACK
- conflict_err  out  1  pulse: illegal lamp pattern
- seq_err  out  1  pulse: legal phase out of order
- timing_err  out  1  pulse: dwell overstay or understay
- err_sticky  out  1  OR of all pulses since reset/clear
- cycles_done  out  8  completed EWY->NSG transitions, wraps 255->0

Behaviour:
- Lamps are synchronous to clk and sampled every rising edge. All outputs are registered.
- Errors assert at the edge that samples the offending pattern and stay high exactly one cycle.
- Decode (combinational):
  - NSG = NS green + EW red only.
  - NSY = NS yellow + EW red only.
  - EWG = NS red + EW green only.
  - EWY = NS red + EW yellow only.
  - Any other pattern (zero or more than one lamp lit per side, both sides non-red) is BAD.
- Reset values: all outputs 0, state SYNC, dwell 0.
- SYNC state:
  - Waits for a legal-to-legal phase change; the first phase seen is mid-dwell and is not timed.
  - Legal phase: record it in prev; no checks.
  - Legal phase different from prev: go to TRACK, dwell=1, phase=new.
  - BAD: conflict_err=1, prev invalidated.
- TRACK state (locked=1):
  - Same phase: dwell++. When dwell reaches the expected value for the current phase, the following same-phase sample fires timing_err once. Dwell then saturates at 2**DW-1 with no further pulses.
  - New legal phase: seq_err if new != successor(old). Successor order is NSG->NSY->EWG->EWY->NSG. timing_err if dwell != expected(old), unless an overstay was already flagged for this dwell. Then dwell=1 and phase=new.
  - Legal EWY->NSG with no error this cycle: cycles_done++.
  - BAD: conflict_err=1, go to SYNC.
  - seq_err does not drop lock. After a seq_err, timing is checked against the new phase.
- Simultaneous events:
  - seq_err and timing_err may fire together.
  - BAD suppresses seq and timing checks.
- err_sticky: set by any pulse; cleared by clear_err. A pulse in the same cycle as clear_err wins (sticky stays 1).
- reset overrides everything, including mid-dwell and mid-error.

Optional Feature:
- Macro: STOPLIGHT_MON_TIMING_EN.
- Defined: dwell counter and timing checks are present as described.
- Undefined: no dwell counter is built; timing_err is tied 0; sequence and conflict checks are unchanged.

Decomposition:
- Package stoplight_pkg holds:
  - phase_t enum (NSG, NSY, EWG, EWY, BAD)
  - mon_state_t enum (SYNC, TRACK)
  - successor function
  - default dwell constants
- Sub-module stoplight_decode: six lamps -> phase_t, purely combinational, reusable by the controller's own assertions.

Test Plan:
- Reset, then drive a legal sequence with dwells 11/4/7/4 for 3 full cycles -> locked=1 after the first change; no error pulses; cycles_done=2 (first NSG is the SYNC-entry phase).
- From TRACK, hold NSG for 12 cycles -> timing_err pulses once, on the 12th sample. A later change to NSY gives no second timing_err and no seq_err.
- Go NSG (11) -> EWG -> seq_err=1 for one cycle, err_sticky=1, locked stays 1, phase=2.
- Drive NS green and EW green together -> conflict_err=1, locked=0. Resume the legal sequence -> relock at the next phase change.
- err_sticky=1, assert clear_err in the same cycle as a new seq_err -> err_sticky stays 1. Assert clear_err alone -> 0 next cycle.
- Assert reset mid-EWG with dwell=3 -> next cycle all outputs 0, locked=0. Build without STOPLIGHT_MON_TIMING_EN and rerun the overstay test -> timing_err remains 0.
